// File: rtl/ula181_serial.sv
// ula181_serial: bit-serial-by-nibble 74181-style ALU.
// Each request is evaluated one 4-bit slice per cycle, LSB slice first, with the
// carry chained between slices. Requests and results use valid/ready handshakes.
// Optional feature macro: ULA181_OVERFLOW_EN adds a registered signed-overflow output 'ovf'.
module ula181_serial #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic [3:0]           s,
  input  logic                 m,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] f,
  output logic                 cout,
  output logic                 aeqb,
  output logic                 busy
`ifdef ULA181_OVERFLOW_EN
  ,
  output logic                 ovf
`endif
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t         state, state_next;
  logic [W-1:0]   a_r, b_r, f_r;
  logic [3:0]     s_r;
  logic           m_r;
  logic           carry;
  logic [CW-1:0]  cnt;
  logic           cout_r, aeqb_r;

  logic [CW+1:0]  base;
  logic [3:0]     sa, sb, x, y, lnib, nib;
  logic [4:0]     sum;
  logic           slice_cout;
  logic [W-1:0]   res_next;
`ifdef ULA181_OVERFLOW_EN
  logic           slice_c3;
  logic           ovf_r;
`endif

  // Evaluate the current slice: operand select, 4-bit add or logic function, and merge into the result
  always_comb begin
    base = {cnt, 2'b00};
    sa   = a_r[base +: 4];
    sb   = b_r[base +: 4];
    x    = '0;
    y    = '0;
    case (s_r)
      4'b0000: begin x = sa;        y = '0;        end
      4'b0001: begin x = sa | sb;   y = '0;        end
      4'b0010: begin x = sa | ~sb;  y = '0;        end
      4'b0011: begin x = '1;        y = '0;        end
      4'b0100: begin x = sa;        y = sa & ~sb;  end
      4'b0101: begin x = sa | sb;   y = sa & ~sb;  end
      4'b0110: begin x = sa;        y = ~sb;       end
      4'b0111: begin x = sa & ~sb;  y = '1;        end
      4'b1000: begin x = sa;        y = sa & sb;   end
      4'b1001: begin x = sa;        y = sb;        end
      4'b1010: begin x = sa | ~sb;  y = sa & sb;   end
      4'b1011: begin x = sa & sb;   y = '1;        end
      4'b1100: begin x = sa;        y = sa;        end
      4'b1101: begin x = sa | sb;   y = sa;        end
      4'b1110: begin x = sa | ~sb;  y = sa;        end
      default: begin x = sa;        y = '1;        end
    endcase
    sum = {1'b0, x} + {1'b0, y} + {4'b0000, carry};

    lnib = '0;
    case (s_r)
      4'b0000: lnib = ~sa;
      4'b0001: lnib = ~(sa | sb);
      4'b0010: lnib = ~sa & sb;
      4'b0011: lnib = '0;
      4'b0100: lnib = ~(sa & sb);
      4'b0101: lnib = ~sb;
      4'b0110: lnib = sa ^ sb;
      4'b0111: lnib = sa & ~sb;
      4'b1000: lnib = ~sa | sb;
      4'b1001: lnib = ~(sa ^ sb);
      4'b1010: lnib = sb;
      4'b1011: lnib = sa & sb;
      4'b1100: lnib = '1;
      4'b1101: lnib = sa | ~sb;
      4'b1110: lnib = sa | sb;
      default: lnib = sa;
    endcase

    nib        = m_r ? lnib : sum[3:0];
    slice_cout = ~m_r & sum[4];
`ifdef ULA181_OVERFLOW_EN
    // carry into the slice MSB recovered from its sum bit and operand bits
    slice_c3   = ~m_r & (x[3] ^ y[3] ^ sum[3]);
`endif
    res_next             = f_r;
    res_next[base +: 4]  = nib;
  end

  // Next-state logic for the IDLE -> EXEC -> DONE sequence
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = EXEC;
      EXEC:    if (cnt == LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and datapath: capture request, accumulate slices, latch final flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      s_r    <= '0;
      m_r    <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
      f_r    <= '0;
      cout_r <= 1'b0;
      aeqb_r <= 1'b0;
`ifdef ULA181_OVERFLOW_EN
      ovf_r  <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            s_r   <= s;
            m_r   <= m;
            carry <= cin & ~m;
            cnt   <= '0;
          end
        end
        EXEC: begin
          f_r   <= res_next;
          carry <= slice_cout;
          if (cnt == LAST) begin
            cout_r <= slice_cout;
            aeqb_r <= &res_next;
`ifdef ULA181_OVERFLOW_EN
            ovf_r  <= slice_c3 ^ slice_cout;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign f         = f_r;
  assign cout      = cout_r;
  assign aeqb      = aeqb_r;
`ifdef ULA181_OVERFLOW_EN
  assign ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_ula181_serial.sv
// Directed self-checking bench for ula181_serial with NIBBLES=4 (16-bit operands).
module tb_ula181_serial;

  localparam int unsigned NIB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic [3:0]  s;
  logic        m, cin;
  logic        out_valid, out_ready;
  logic [15:0] f;
  logic        cout, aeqb, busy;
`ifdef ULA181_OVERFLOW_EN
  logic        ovf;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  ula181_serial #(.NIBBLES(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .s         (s),
    .m         (m),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .cout      (cout),
    .aeqb      (aeqb),
    .busy      (busy)
`ifdef ULA181_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Full request/response transaction; called at #1 after a rising edge with the DUT idle
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [3:0] sv, input logic mv, input logic cv,
                        input logic [15:0] ef, input logic ec, input logic eq, input logic eo);
    int unsigned cyc;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = av; b = bv; s = sv; m = mv; cin = cv;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; cin = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, cyc, NIB);
    check({tag, "_f"}, 32'(f), 32'(ef));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_aeqb"}, 32'(aeqb), 32'(eq));
`ifdef ULA181_OVERFLOW_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: %s overflow expectation undefined", tag);
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_released"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] res;
  } lvec_t;

  lvec_t ltab[16];

  initial begin
    // a=0x0003, b=0x0006 logic results, hand-computed
    ltab[0]  = '{4'b0000, 16'hFFFC};
    ltab[1]  = '{4'b0001, 16'hFFF8};
    ltab[2]  = '{4'b0010, 16'h0004};
    ltab[3]  = '{4'b0011, 16'h0000};
    ltab[4]  = '{4'b0100, 16'hFFFD};
    ltab[5]  = '{4'b0101, 16'hFFF9};
    ltab[6]  = '{4'b0110, 16'h0005};
    ltab[7]  = '{4'b0111, 16'h0001};
    ltab[8]  = '{4'b1000, 16'hFFFE};
    ltab[9]  = '{4'b1001, 16'hFFFA};
    ltab[10] = '{4'b1010, 16'h0006};
    ltab[11] = '{4'b1011, 16'h0002};
    ltab[12] = '{4'b1100, 16'hFFFF};
    ltab[13] = '{4'b1101, 16'hFFFB};
    ltab[14] = '{4'b1110, 16'h0007};
    ltab[15] = '{4'b1111, 16'h0003};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; s = '0; m = 1'b0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_f", 32'(f), 32'h0);
    check("reset_flags", {27'd0, cout, aeqb, out_valid, busy, in_ready}, 32'b00001);

    // arithmetic vectors
    run_op("add_3_6",    16'h0003, 16'h0006, 4'b1001, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b0);
    run_op("sub_3_6",    16'h0003, 16'h0006, 4'b0110, 1'b0, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0);
    run_op("carry_wrap", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("ovf_7fff",   16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
    run_op("inc_a",      16'h00FF, 16'h1234, 4'b0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    run_op("a_plus_a",   16'h8001, 16'h0000, 4'b1100, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b1);
    run_op("minus_one",  16'h1234, 16'h5678, 4'b0011, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    run_op("a_minus_1",  16'h0005, 16'h0000, 4'b1111, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0);

    // logic sweep; cin=1 must not leak into cout
    for (int i = 0; i < 16; i++)
      run_op($sformatf("logic_s%0d", i), 16'h0003, 16'h0006, ltab[i].sel, 1'b1, 1'b1,
             ltab[i].res, 1'b0, (ltab[i].res == 16'hFFFF), 1'b0);

    // result held in DONE while out_ready is low; new requests ignored
    in_valid = 1'b1; a = 16'h0003; b = 16'h0006; s = 4'b1001; m = 1'b0; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (NIB) begin @(posedge clk); #1; end
    check("hold_enter", 32'(out_valid), 32'd1);
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; s = 4'b0110; m = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold_c%0d", k), {12'd0, f, out_valid, in_ready, cout, aeqb},
            {12'd0, 16'h0009, 4'b1000});
    end
    in_valid = 1'b0; m = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold_release", {30'd0, out_valid, in_ready}, 32'b01);

    // reset in the middle of EXEC (cnt==2) aborts the operation
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; s = 4'b1001; m = 1'b0; cin = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_f", 32'(f), 32'h0);
    check("abort_flags", {29'd0, out_valid, busy, in_ready}, 32'b001);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort_idle%0d", k), 32'(out_valid), 32'd0);
    end
    run_op("after_abort", 16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b1, 16'h3334, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
